// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C master core between NUM_REQ register-access
// requesters. Round-robin grant, single command per grant, watchdog abort,
// and a one-cycle response pulse back to the granted requester.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 200_000,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW            = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_rw_i,
    input  logic [NUM_REQ*7-1:0]          req_taddr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_raddr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [GW-1:0]                 grant_id_o,
    output logic                          mst_start_o,
    output logic                          mst_abort_o,
    output logic                          mst_rw_o,
    output logic [6:0]                    mst_taddr_o,
    output logic [DATA_WIDTH-1:0]         mst_raddr_o,
    output logic [DATA_WIDTH-1:0]         mst_wdata_o,
    input  logic                          mst_busy_i,
    input  logic                          mst_done_i,
    input  logic                          mst_nack_i,
    input  logic [DATA_WIDTH-1:0]         mst_rdata_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           rr_q;
    logic [GW-1:0]           grant_q;
    logic [TW-1:0]           timer_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    mst_start_q;
    logic                    mst_abort_q;
    logic                    mst_rw_q;
    logic [6:0]              mst_taddr_q;
    logic [DATA_WIDTH-1:0]   mst_raddr_q;
    logic [DATA_WIDTH-1:0]   mst_wdata_q;

    logic [GW-1:0]           grant_d;
    logic                    found_d;
    int                      pick_idx;
    int                      scan_idx;

    // Round-robin pick: scan from the rr pointer downwards in priority so the
    // last hit written is the first valid index at or after the pointer.
    always_comb begin
        grant_d  = '0;
        found_d  = 1'b0;
        pick_idx = 0;
        scan_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req_valid_i[scan_idx]) begin
                pick_idx = scan_idx;
                found_d  = 1'b1;
            end
        end
        grant_d = GW'(pick_idx);
    end

    // Main FSM: grant, issue, wait for done or watchdog, respond. The timer
    // is loaded at grant so it counts cycles from the mst_start cycle, which
    // places the abort pulse exactly TIMEOUT_CYCLES after mst_start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            timer_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mst_start_q <= 1'b0;
            mst_abort_q <= 1'b0;
            mst_rw_q    <= 1'b0;
            mst_taddr_q <= '0;
            mst_raddr_q <= '0;
            mst_wdata_q <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            mst_start_q <= 1'b0;
            mst_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d && !mst_busy_i) begin
                        grant_q               <= grant_d;
                        mst_rw_q              <= req_rw_i[pick_idx];
                        mst_taddr_q           <= req_taddr_i[7*pick_idx +: 7];
                        mst_raddr_q           <= req_raddr_i[DATA_WIDTH*pick_idx +: DATA_WIDTH];
                        mst_wdata_q           <= req_wdata_i[DATA_WIDTH*pick_idx +: DATA_WIDTH];
                        timer_q               <= TW'(TIMEOUT_CYCLES - 1);
                        req_ready_q[pick_idx] <= 1'b1;
                        mst_start_q           <= 1'b1;
                        state_q               <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= timer_q - 1'b1;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mst_done_i) begin
                        rsp_err_q            <= mst_nack_i;
                        rsp_rdata_q          <= (mst_rw_q && !mst_nack_i) ? mst_rdata_i : '0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        state_q              <= RESP;
                    end else if (timer_q == '0) begin
                        mst_abort_q          <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_rdata_q          <= '0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        state_q              <= RESP;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                RESP: begin
                    rr_q    <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign grant_id_o  = grant_q;
    assign mst_start_o = mst_start_q;
    assign mst_abort_o = mst_abort_q;
    assign mst_rw_o    = mst_rw_q;
    assign mst_taddr_o = mst_taddr_q;
    assign mst_raddr_o = mst_raddr_q;
    assign mst_wdata_o = mst_wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed vectors plus hand-written multi-cycle sequences
// for round-robin order, watchdog abort, busy hold-off and mid-flight reset.
module tb_i2c_req_arbiter;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_rw;
    logic [NR*7-1:0] req_taddr;
    logic [NR*DW-1:0] req_raddr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [0:0]      grant_id;
    logic            mst_start;
    logic            mst_abort;
    logic            mst_rw;
    logic [6:0]      mst_taddr;
    logic [DW-1:0]   mst_raddr;
    logic [DW-1:0]   mst_wdata;
    logic            mst_busy;
    logic            mst_done;
    logic            mst_nack;
    logic [DW-1:0]   mst_rdata;

    int assertCount = 0;
    int failCount   = 0;

    i2c_req_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstn),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_rw_i(req_rw),
        .req_taddr_i(req_taddr),
        .req_raddr_i(req_raddr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .grant_id_o(grant_id),
        .mst_start_o(mst_start),
        .mst_abort_o(mst_abort),
        .mst_rw_o(mst_rw),
        .mst_taddr_o(mst_taddr),
        .mst_raddr_o(mst_raddr),
        .mst_wdata_o(mst_wdata),
        .mst_busy_i(mst_busy),
        .mst_done_i(mst_done),
        .mst_nack_i(mst_nack),
        .mst_rdata_i(mst_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        bit         rw;
        logic [6:0] taddr;
        logic [7:0] raddr;
        logic [7:0] wdata;
        int         lat;
        bit         nack;
        logic [7:0] rdin;
        bit         expErr;
        logic [7:0] expRdata;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] allOut();
        return {24'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id,
                mst_start, mst_abort, mst_rw, mst_taddr, mst_raddr, mst_wdata};
    endfunction

    task automatic setReq(input int r, input bit rw, input logic [6:0] ta,
                          input logic [7:0] ra, input logic [7:0] wd);
        req_valid[r]         = 1'b1;
        req_rw[r]            = rw;
        req_taddr[7*r +: 7]  = ta;
        req_raddr[DW*r +: DW] = ra;
        req_wdata[DW*r +: DW] = wd;
    endtask

    task automatic waitStart(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < 64) begin
            tick();
            cycles++;
            ok = mst_start;
        end
        if (!ok) checkOutput("startSeen", 64'd0, 64'd1);
    endtask

    // Master side: wait lat cycles in WAIT_DONE, pulse done, check the
    // response pulse one cycle later and its drop the cycle after.
    task automatic completeTxn(input int r, input int lat, input bit nack, input logic [7:0] rdin,
                               input bit expErr, input logic [7:0] expRd, input string tag);
        logic [1:0] expV;
        expV = 2'b01 << r;
        repeat (lat) tick();
        checkOutput({tag, "_noAbort"}, {63'd0, mst_abort}, 64'd0);
        mst_done  = 1'b1;
        mst_nack  = nack;
        mst_rdata = rdin;
        tick();
        mst_done  = 1'b0;
        mst_nack  = 1'b0;
        mst_rdata = '0;
        checkOutput({tag, "_rspValid"}, {62'd0, rsp_valid}, {62'd0, expV});
        checkOutput({tag, "_rspErr"}, {63'd0, rsp_err}, {63'd0, expErr});
        checkOutput({tag, "_rspRdata"}, {56'd0, rsp_rdata}, {56'd0, expRd});
        tick();
        checkOutput({tag, "_rspDrop"}, {62'd0, rsp_valid}, 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc;
        bit ok;
        logic [1:0] expR;
        expR = 2'b01 << v.r;
        setReq(v.r, v.rw, v.taddr, v.raddr, v.wdata);
        waitStart(cyc, ok);
        req_valid[v.r] = 1'b0;
        if (ok) begin
            checkOutput({tag, "_latency"}, 64'(cyc), 64'd1);
            checkOutput({tag, "_ready"}, {62'd0, req_ready}, {62'd0, expR});
            checkOutput({tag, "_grantId"}, {63'd0, grant_id}, 64'(v.r));
            checkOutput({tag, "_mstCmd"}, {39'd0, mst_rw, mst_taddr, mst_raddr, mst_wdata},
                        {39'd0, v.rw, v.taddr, v.raddr, v.wdata});
            completeTxn(v.r, v.lat, v.nack, v.rdin, v.expErr, v.expRdata, tag);
        end
    endtask

    task automatic doReset();
        rstn = 1'b0;
        repeat (3) tick();
        checkOutput("resetOutputs", allOut(), 64'd0);
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        bit ok;
        bit saw;
        logic [1:0] expR;

        vecs[0] = '{0, 1'b0, 7'h50, 8'h10, 8'hA5, 2, 1'b0, 8'h77, 1'b0, 8'h00};
        vecs[1] = '{0, 1'b1, 7'h50, 8'h20, 8'h00, 1, 1'b0, 8'hBE, 1'b0, 8'hBE};
        vecs[2] = '{1, 1'b1, 7'h3A, 8'h05, 8'h00, 3, 1'b1, 8'h99, 1'b1, 8'h00};
        vecs[3] = '{1, 1'b0, 7'h22, 8'hFF, 8'h5A, 1, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[4] = '{0, 1'b1, 7'h7F, 8'h00, 8'h00, 5, 1'b0, 8'h01, 1'b0, 8'h01};

        req_valid = '0; req_rw = '0; req_taddr = '0; req_raddr = '0; req_wdata = '0;
        mst_busy = 1'b0; mst_done = 1'b0; mst_nack = 1'b0; mst_rdata = '0;
        rstn = 1'b1;
        #2;
        doReset();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray done while idle must not produce a response.
        mst_done = 1'b1;
        tick();
        mst_done = 1'b0;
        tick();
        checkOutput("strayDone", {62'd0, rsp_valid}, 64'd0);

        // Round robin with both requesters continuously valid.
        doReset();
        setReq(0, 1'b0, 7'h11, 8'h01, 8'hC0);
        setReq(1, 1'b0, 7'h22, 8'h02, 8'hC1);
        for (int i = 0; i < 4; i++) begin
            waitStart(cyc, ok);
            if (i == 3) req_valid = '0;
            if (ok) begin
                expR = 2'b01 << (i % 2);
                checkOutput($sformatf("rr%0d_spacing", i), 64'(cyc), 64'd1);
                checkOutput($sformatf("rr%0d_ready", i), {62'd0, req_ready}, {62'd0, expR});
                checkOutput($sformatf("rr%0d_grant", i), {63'd0, grant_id}, 64'(i % 2));
                checkOutput($sformatf("rr%0d_taddr", i), {57'd0, mst_taddr},
                            (i % 2 == 0) ? 64'h11 : 64'h22);
                completeTxn(i % 2, 1, 1'b0, 8'h00, 1'b0, 8'h00, $sformatf("rr%0d", i));
            end
        end
        req_valid = '0;

        // Watchdog: no done, abort exactly TO cycles after start.
        setReq(0, 1'b1, 7'h41, 8'h33, 8'h00);
        waitStart(cyc, ok);
        req_valid = '0;
        if (ok) begin
            repeat (TO - 1) tick();
            checkOutput("toAbortEarly", {63'd0, mst_abort}, 64'd0);
            tick();
            checkOutput("toAbort", {63'd0, mst_abort}, 64'd1);
            checkOutput("toRspValid", {62'd0, rsp_valid}, 64'd1);
            checkOutput("toRspErr", {63'd0, rsp_err}, 64'd1);
            checkOutput("toRspRdata", {56'd0, rsp_rdata}, 64'd0);
            tick();
            checkOutput("toAbortPulse", {63'd0, mst_abort}, 64'd0);
        end

        // Done arriving in the same cycle the timer expires wins.
        setReq(1, 1'b1, 7'h42, 8'h34, 8'h00);
        waitStart(cyc, ok);
        req_valid = '0;
        if (ok) begin
            checkOutput("tieGrant", {63'd0, grant_id}, 64'd1);
            repeat (TO - 1) tick();
            mst_done = 1'b1; mst_nack = 1'b0; mst_rdata = 8'h3C;
            tick();
            mst_done = 1'b0; mst_rdata = '0;
            checkOutput("tieNoAbort", {63'd0, mst_abort}, 64'd0);
            checkOutput("tieRspValid", {62'd0, rsp_valid}, 64'd2);
            checkOutput("tieRspErr", {63'd0, rsp_err}, 64'd0);
            checkOutput("tieRspRdata", {56'd0, rsp_rdata}, 64'h3C);
            tick();
        end

        // Busy master holds off the grant; start follows one cycle after release.
        mst_busy = 1'b1;
        setReq(1, 1'b0, 7'h55, 8'h66, 8'h77);
        saw = 1'b0;
        repeat (5) begin
            tick();
            saw = saw | mst_start;
        end
        checkOutput("busyNoGrant", {63'd0, saw}, 64'd0);
        mst_busy = 1'b0;
        waitStart(cyc, ok);
        req_valid = '0;
        if (ok) begin
            checkOutput("busyLatency", 64'(cyc), 64'd1);
            checkOutput("busyReady", {62'd0, req_ready}, 64'd2);
            completeTxn(1, 2, 1'b0, 8'h00, 1'b0, 8'h00, "busy");
        end

        // Leave the rr pointer at 1, then reset a req1 transaction in flight.
        applyStimulus(vecs[0], "preReset");
        setReq(1, 1'b0, 7'h2B, 8'h4C, 8'h5D);
        waitStart(cyc, ok);
        req_valid = '0;
        if (ok) checkOutput("midGrant", {63'd0, grant_id}, 64'd1);
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        checkOutput("midResetOutputs", allOut(), 64'd0);
        saw = 1'b0;
        repeat (3) begin
            tick();
            saw = saw | (|rsp_valid);
        end
        checkOutput("midResetNoRsp", {63'd0, saw}, 64'd0);
        rstn = 1'b1;
        tick();
        setReq(0, 1'b0, 7'h01, 8'h02, 8'h03);
        setReq(1, 1'b0, 7'h04, 8'h05, 8'h06);
        waitStart(cyc, ok);
        req_valid = '0;
        if (ok) begin
            checkOutput("postResetRr", {62'd0, req_ready}, 64'd1);
            completeTxn(0, 1, 1'b0, 8'h00, 1'b0, 8'h00, "postReset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
